// File: rtl/hex_display_arbiter.sv
// hex_display_arbiter
//   Shares the six HEX displays between two requesters (A, B). Ownership is
//   granted round-robin with a minimum time slice of HOLD_CYCLES before a
//   contending requester may preempt. The owner's 24-bit value is decoded to
//   active-low seven-segment codes, one nibble per display.
// Ports:
//   CLOCK_50        rising-edge clock
//   Reset           synchronous, active-high
//   req_a / req_b   level requests
//   data_a / data_b 24-bit values, nibble k drives HEXk
//   gnt_a / gnt_b   registered ownership (one-hot or idle)
//   busy            gnt_a | gnt_b
//   HEX0..HEX5      registered active-low segments, bit0=a .. bit6=g

// Per-digit decoder: one hex nibble to active-low segments.
module hex_seg_lane (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end
endmodule

module hex_display_arbiter #(
  parameter int HOLD_CYCLES = 50000000,
  parameter int NUM_LANES   = 6
) (
  input  logic        CLOCK_50,
  input  logic        Reset,
  input  logic        req_a,
  input  logic [23:0] data_a,
  input  logic        req_b,
  input  logic [23:0] data_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        busy,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5
);
  localparam int CW = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic last_b, last_b_nxt;   // 1: B owned last, so A wins the next tie

  logic [23:0] owner_data;
  logic [NUM_LANES-1:0][6:0] seg_w, hex_q;

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      last_b <= 1'b1;
      hex_q  <= {NUM_LANES{7'h7F}};
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      last_b <= last_b_nxt;
      // Display follows the owner as of the state before this edge.
      hex_q  <= (state == IDLE) ? {NUM_LANES{7'h7F}} : seg_w;
    end
  end

  always_comb begin
    state_nxt  = state;
    last_b_nxt = last_b;
    case (state)
      IDLE: begin
        if (req_a && req_b) state_nxt = last_b ? OWN_A : OWN_B;
        else if (req_a)     state_nxt = OWN_A;
        else if (req_b)     state_nxt = OWN_B;
      end
      OWN_A: begin
        if (!req_a || (req_b && cnt == CNT_MAX)) begin
          last_b_nxt = 1'b0;
          state_nxt  = req_b ? OWN_B : IDLE;
        end
      end
      OWN_B: begin
        if (!req_b || (req_a && cnt == CNT_MAX)) begin
          last_b_nxt = 1'b1;
          state_nxt  = req_a ? OWN_A : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Slice counter restarts on every ownership entry and saturates.
  always_comb begin
    cnt_nxt = cnt;
    if (state == IDLE || state_nxt != state) cnt_nxt = '0;
    else if (cnt != CNT_MAX)                 cnt_nxt = cnt + 1'b1;
  end

  assign owner_data = (state == OWN_B) ? data_b : data_a;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    hex_seg_lane u_lane (
      .nib (owner_data[4*k +: 4]),
      .seg (seg_w[k])
    );
  end

  assign gnt_a = (state == OWN_A);
  assign gnt_b = (state == OWN_B);
  assign busy  = gnt_a | gnt_b;
  assign HEX0  = hex_q[0];
  assign HEX1  = hex_q[1];
  assign HEX2  = hex_q[2];
  assign HEX3  = hex_q[3];
  assign HEX4  = hex_q[4];
  assign HEX5  = hex_q[5];
endmodule

// File: tb/tb_hex_display_arbiter.sv
// tb_hex_display_arbiter
//   Directed scenarios plus randomized traffic against a cycle-level model of
//   the arbitration rules (owner, cycles owned, last owner, displayed codes).
module tb_hex_display_arbiter;
  localparam int HOLD = 4;

  logic        CLOCK_50 = 1'b0;
  logic        Reset;
  logic        req_a, req_b;
  logic [23:0] data_a, data_b;
  logic        gnt_a, gnt_b, busy;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  hex_display_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .CLOCK_50 (CLOCK_50),
    .Reset    (Reset),
    .req_a    (req_a),
    .data_a   (data_a),
    .req_b    (req_b),
    .data_b   (data_b),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .busy     (busy),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .HEX3     (HEX3),
    .HEX4     (HEX4),
    .HEX5     (HEX5)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner 0=none 1=A 2=B
  logic [6:0] seg_tab [16];
  int         m_owner, m_held, m_last;
  logic [6:0] m_hex [6];

  task automatic model_edge();
    int mine, other, y;
    logic [23:0] d;
    if (Reset) begin
      m_owner = 0; m_held = 0; m_last = 2;
      for (int k = 0; k < 6; k++) m_hex[k] = 7'h7F;
      return;
    end
    d = (m_owner == 2) ? data_b : data_a;
    for (int k = 0; k < 6; k++)
      m_hex[k] = (m_owner == 0) ? 7'h7F : seg_tab[(d >> (4*k)) & 24'hF];
    if (m_owner == 0) begin
      if (req_a && req_b) m_owner = (m_last == 1) ? 2 : 1;
      else if (req_a)     m_owner = 1;
      else if (req_b)     m_owner = 2;
      m_held = 0;
    end else begin
      mine  = (m_owner == 1) ? int'(req_a) : int'(req_b);
      other = (m_owner == 1) ? int'(req_b) : int'(req_a);
      y     = 3 - m_owner;
      if (mine == 0 || (other == 1 && m_held >= HOLD - 1)) begin
        m_last  = m_owner;
        m_owner = other ? y : 0;
        m_held  = 0;
      end else begin
        m_held = m_held + 1;
      end
    end
  endtask

  task automatic check_all();
    chk("gnt_a", 32'(gnt_a), 32'(m_owner == 1));
    chk("gnt_b", 32'(gnt_b), 32'(m_owner == 2));
    chk("busy",  32'(busy),  32'(m_owner != 0));
    chk("onehot", 32'(gnt_a & gnt_b), 32'd0);
    chk("hex0", 32'(HEX0), 32'(m_hex[0]));
    chk("hex1", 32'(HEX1), 32'(m_hex[1]));
    chk("hex2", 32'(HEX2), 32'(m_hex[2]));
    chk("hex3", 32'(HEX3), 32'(m_hex[3]));
    chk("hex4", 32'(HEX4), 32'(m_hex[4]));
    chk("hex5", 32'(HEX5), 32'(m_hex[5]));
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    seg_tab[0]  = 7'h40; seg_tab[1]  = 7'h79; seg_tab[2]  = 7'h24; seg_tab[3]  = 7'h30;
    seg_tab[4]  = 7'h19; seg_tab[5]  = 7'h12; seg_tab[6]  = 7'h02; seg_tab[7]  = 7'h78;
    seg_tab[8]  = 7'h00; seg_tab[9]  = 7'h10; seg_tab[10] = 7'h08; seg_tab[11] = 7'h03;
    seg_tab[12] = 7'h46; seg_tab[13] = 7'h21; seg_tab[14] = 7'h06; seg_tab[15] = 7'h0E;
    m_owner = 0; m_held = 0; m_last = 2;
    for (int k = 0; k < 6; k++) m_hex[k] = 7'h7F;

    Reset = 1; req_a = 0; req_b = 0; data_a = '0; data_b = '0;
    #2;
    tick(); tick();
    Reset = 0;
    repeat (5) tick();
    chk("idle_hex0_blank", 32'(HEX0), 32'h7F);
    chk("idle_busy", 32'(busy), 32'd0);

    // Single requester: grant then decoded data
    req_a = 1; data_a = 24'h012345;
    tick();
    chk("a_grant", 32'(gnt_a), 32'd1);
    tick();
    chk("a_hex", {4'd0, HEX5, HEX4, HEX3, HEX2}, {4'd0, 7'h40, 7'h79, 7'h24, 7'h30});
    chk("a_hex_lo", {18'd0, HEX1, HEX0}, {18'd0, 7'h19, 7'h12});

    // Uncontended hold, then B contends after saturation
    repeat (20) tick();
    req_b = 1; data_b = 24'hFFFFFF;
    tick();
    chk("b_preempt_sat", 32'(gnt_b), 32'd1);
    tick();
    chk("b_hex_f", 32'(HEX3), 32'h0E);

    // Both held: round robin every HOLD cycles
    repeat (12) tick();

    // Early release by A at cnt=1
    Reset = 1; tick(); Reset = 0; req_a = 0; req_b = 0; tick();
    req_a = 1; tick(); tick();
    req_b = 1; req_a = 0; tick();
    chk("early_release", 32'(gnt_b), 32'd1);
    tick();
    chk("early_hex", 32'(HEX0), 32'h0E);

    // Reset mid-ownership of B, then simultaneous requests favour A
    Reset = 1; tick();
    chk("rst_gnt_b", 32'(gnt_b), 32'd0);
    chk("rst_hex", 32'(HEX5), 32'h7F);
    Reset = 0; req_a = 1; req_b = 1; tick();
    chk("tie_a_first", 32'(gnt_a), 32'd1);
    repeat (10) tick();

    // Random traffic with sticky requests
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) req_a = ~req_a;
      if ($urandom_range(7) == 0) req_b = ~req_b;
      if ($urandom_range(3) == 0) data_a = 24'($urandom);
      if ($urandom_range(3) == 0) data_b = 24'($urandom);
      Reset = ($urandom_range(99) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
